fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Program-counter and fetch-sequencing block directly upstream of the instruction ROM. Drives the 12-bit instruction address each cycle. Handles start/halt handshake with the testbench/top level, stalls, absolute jumps and signed relative branches. Address output is registered, so the ROM's combinational read gives the instruction in the same cycle the address is presented.

Parameters:
AW, 12, instruction address width (ROM depth 2^AW)
OW, 8, signed relative-branch offset width
RESET_ADDR, 0, address held after reset and while idle

Ports:
Clk  input  1  system clock; all state updates on rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  one-cycle request to begin execution at StartAddr
StartAddr  input  AW  program entry address, sampled with Start
Stall  input  1  hold current address (RUN only)
Halt  input  1  end of program, from decoder (RUN only)
BranchEn  input  1  take a control transfer this cycle
BranchAbs  input  1  1 = absolute jump to BranchTarget, 0 = relative by BranchOffset
BranchTarget  input  AW  absolute jump target
BranchOffset  input  OW  two's-complement offset relative to current address
InstAddress  output  AW  address to instruction ROM (registered)
Running  output  1  high while state is RUN
Done  output  1  high while state is DONE

Behaviour:
- Interface: one clock (Clk); Reset synchronous, active-high; Reset overrides all other inputs in the same edge.
- Reset values: state IDLE, InstAddress = RESET_ADDR, Running = 0, Done = 0.
- States: IDLE, RUN, DONE; Running/Done decoded from the state register (no extra latency).
- IDLE: Start=1 -> InstAddress <= StartAddr, state <= RUN. All other inputs ignored. Start=0 -> hold.
- RUN: per-edge priority Halt > Stall > BranchEn > increment.
  - Halt=1 -> state <= DONE, InstAddress held (the halting instruction's address stays visible).
  - Stall=1 -> InstAddress held, state RUN.
  - BranchEn=1, BranchAbs=1 -> InstAddress <= BranchTarget.
  - BranchEn=1, BranchAbs=0 -> InstAddress <= InstAddress + sign_extend(BranchOffset), computed modulo 2^AW.
  - Otherwise InstAddress <= InstAddress + 1 modulo 2^AW (4095 -> 0, no flag).
  - Start in RUN is ignored.
- DONE: InstAddress held, Done=1. Start=1 -> InstAddress <= StartAddr, state <= RUN, Done drops on that edge. Start=0 -> stay.
- Zero relative offset: address unchanged (self-loop). Legal, not an error.
- Reset asserted mid-RUN or DONE: next edge gives IDLE, RESET_ADDR, Running=0, Done=0, regardless of Halt/Stall/Branch.
- Branch inputs are don't-care when BranchEn=0. BranchAbs, BranchTarget and BranchOffset must still not propagate X into InstAddress.
- No combinational path from any input to InstAddress.

Decomposition:
- Shared package fetch_pkg: AW/OW localparams, typedef addr_t (logic [AW-1:0]), typedef off_t (logic signed [OW-1:0]), enum fetch_state_t {IDLE, RUN, DONE}.
- One sub-module: pc_next, purely combinational. Inputs: current address and the branch/stall controls. Output: the RUN-state next address, including the sign-extend and modulo add.
- fetch_ctrl keeps the FSM and registers.

Test Plan:
- Reset -> InstAddress=0, Running=0, Done=0. Hold Reset 3 cycles with Start=1 -> still IDLE at 0.
- Start=1, StartAddr=0x010, then 4 free-run cycles -> addresses 0x010, 0x011, 0x012, 0x013, 0x014. Running=1 from the first edge.
- At 0x020: BranchEn=1, BranchAbs=0, BranchOffset=-3 (0xFD) -> 0x01D. Next cycle BranchAbs=1, BranchTarget=0xABC -> 0xABC.
- Start at 0xFFE, free-run -> 0xFFE, 0xFFF, 0x000. At 0x002, offset -5 -> 0xFFD (wrap both ways).
- At 0x030: Stall=1 with BranchEn=1 for 2 cycles -> holds 0x030. Stall drops -> branch taken. Halt+Stall+BranchEn together -> DONE, address 0x030, Done=1.
- From DONE, Start with StartAddr=0x100 -> RUN, 0x100, Done=0. Reset asserted mid-RUN at 0x105 -> next edge IDLE, 0x000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the fetch sequencer: address/offset widths and FSM state encoding.
// Pure declarations; no logic.
package fetch_pkg;
  localparam int AW = 12;
  localparam int OW = 8;

  typedef logic [AW-1:0] addr_t;
  typedef logic signed [OW-1:0] off_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/pc_next.sv
// Combinational next-address for the RUN state: stall hold, absolute/relative branch, increment.
// Zero latency; no backpressure (stall is just one of the select inputs).
module pc_next #(
  parameter int AW = 12,
  parameter int OW = 8
) (
  input  logic [AW-1:0] addr,
  input  logic          stall,
  input  logic          branch_en,
  input  logic          branch_abs,
  input  logic [AW-1:0] branch_target,
  input  logic [OW-1:0] branch_offset,
  output logic [AW-1:0] next_addr
);
  logic [AW-1:0] offset_ext;

  assign offset_ext = {{(AW-OW){branch_offset[OW-1]}}, branch_offset};

  // Nested ifs keep X on the branch operands away from the result when branch_en=0.
  always_comb begin
    next_addr = addr + AW'(1);
    if (stall) begin
      next_addr = addr;
    end else if (branch_en) begin
      if (branch_abs) begin
        next_addr = branch_target;
      end else begin
        next_addr = addr + offset_ext;
      end
    end
  end
endmodule

// File: rtl/fetch_ctrl.sv
// Program counter and IDLE/RUN/DONE sequencer driving the instruction ROM address.
// Address is registered (one edge from controls to InstAddress); Stall holds the address in RUN.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int            AW         = 12,
  parameter int            OW         = 8,
  parameter logic [AW-1:0] RESET_ADDR = '0
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [AW-1:0] StartAddr,
  input  logic          Stall,
  input  logic          Halt,
  input  logic          BranchEn,
  input  logic          BranchAbs,
  input  logic [AW-1:0] BranchTarget,
  input  logic [OW-1:0] BranchOffset,
  output logic [AW-1:0] InstAddress,
  output logic          Running,
  output logic          Done
);
  fetch_state_t  state;
  logic [AW-1:0] run_next;

  pc_next #(
    .AW(AW),
    .OW(OW)
  ) u_pc_next (
    .addr         (InstAddress),
    .stall        (Stall),
    .branch_en    (BranchEn),
    .branch_abs   (BranchAbs),
    .branch_target(BranchTarget),
    .branch_offset(BranchOffset),
    .next_addr    (run_next)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      InstAddress <= RESET_ADDR;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            state       <= RUN;
            InstAddress <= StartAddr;
          end
        end
        RUN: begin
          // Halt keeps the halting instruction's address visible.
          if (Halt) begin
            state <= DONE;
          end else begin
            InstAddress <= run_next;
          end
        end
        default: begin
          state       <= IDLE;
          InstAddress <= RESET_ADDR;
        end
      endcase
    end
  end

  assign Running = (state == RUN);
  assign Done    = (state == DONE);
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed-vector bench for fetch_ctrl: each task drives a scenario and checks address/Running/Done.
module tb_fetch_ctrl;
  logic        Clk = 1'b0;
  logic        Reset, Start, Stall, Halt, BranchEn, BranchAbs;
  logic [11:0] StartAddr, BranchTarget, InstAddress;
  logic [7:0]  BranchOffset;
  logic        Running, Done;

  int vectors = 0;
  int miscompares = 0;

  fetch_ctrl dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .StartAddr   (StartAddr),
    .Stall       (Stall),
    .Halt        (Halt),
    .BranchEn    (BranchEn),
    .BranchAbs   (BranchAbs),
    .BranchTarget(BranchTarget),
    .BranchOffset(BranchOffset),
    .InstAddress (InstAddress),
    .Running     (Running),
    .Done        (Done)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    Reset = 1'b0; Start = 1'b0; StartAddr = 12'h000; Stall = 1'b0; Halt = 1'b0;
    BranchEn = 1'b0; BranchAbs = 1'b0; BranchTarget = 12'h000; BranchOffset = 8'h00;
  endtask

  task automatic test_reset();
    idle_inputs();
    Reset = 1'b1; Start = 1'b1; StartAddr = 12'h123;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if ({InstAddress, Running, Done} !== {12'h000, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL reset_hold[%0d]: got addr=%h run=%b done=%b, want addr=000 run=0 done=0",
                 i, InstAddress, Running, Done);
      end
    end
    Reset = 1'b0; Start = 1'b0;
    step();
    vectors++;
    if ({InstAddress, Running, Done} !== {12'h000, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL idle_hold: got addr=%h run=%b done=%b, want addr=000 run=0 done=0",
               InstAddress, Running, Done);
    end
  endtask

  task automatic test_free_run();
    logic [11:0] exp;
    Start = 1'b1; StartAddr = 12'h010;
    step();
    Start = 1'b0; StartAddr = 12'h000;
    exp = 12'h010;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({InstAddress, Running, Done} !== {exp, 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL free_run[%0d]: got addr=%h run=%b done=%b, want addr=%h run=1 done=0",
                 i, InstAddress, Running, Done, exp);
      end
      if (i < 4) step();
      exp = exp + 12'h001;
    end
  endtask

  task automatic test_branch();
    BranchEn = 1'b1; BranchAbs = 1'b1; BranchTarget = 12'h020;
    step();
    BranchAbs = 1'b0; BranchOffset = 8'hFD;
    step();
    vectors++;
    if (InstAddress !== 12'h01D) begin
      miscompares++;
      $display("FAIL rel_branch_neg: got addr=%h, want 01d", InstAddress);
    end
    BranchAbs = 1'b1; BranchTarget = 12'hABC;
    step();
    vectors++;
    if (InstAddress !== 12'hABC) begin
      miscompares++;
      $display("FAIL abs_branch: got addr=%h, want abc", InstAddress);
    end
    BranchEn = 1'b0; BranchAbs = 1'bx; BranchTarget = 12'hxxx; BranchOffset = 8'hxx;
    step();
    vectors++;
    if (InstAddress !== 12'hABD) begin
      miscompares++;
      $display("FAIL x_branch_ops: got addr=%h, want abd", InstAddress);
    end
    BranchEn = 1'b1; BranchAbs = 1'b0; BranchTarget = 12'h000; BranchOffset = 8'h00;
    step();
    vectors++;
    if (InstAddress !== 12'hABD) begin
      miscompares++;
      $display("FAIL zero_offset: got addr=%h, want abd", InstAddress);
    end
    BranchEn = 1'b0; Start = 1'b1; StartAddr = 12'h555;
    step();
    Start = 1'b0;
    vectors++;
    if ({InstAddress, Running, Done} !== {12'hABE, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL start_in_run: got addr=%h run=%b done=%b, want addr=abe run=1 done=0",
               InstAddress, Running, Done);
    end
  endtask

  task automatic test_halt_restart_wrap();
    logic [11:0] exp;
    Halt = 1'b1;
    step();
    Halt = 1'b0;
    vectors++;
    if ({InstAddress, Running, Done} !== {12'hABE, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL halt: got addr=%h run=%b done=%b, want addr=abe run=0 done=1",
               InstAddress, Running, Done);
    end
    step();
    vectors++;
    if ({InstAddress, Running, Done} !== {12'hABE, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL done_hold: got addr=%h run=%b done=%b, want addr=abe run=0 done=1",
               InstAddress, Running, Done);
    end
    Start = 1'b1; StartAddr = 12'hFFE;
    step();
    Start = 1'b0;
    exp = 12'hFFE;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({InstAddress, Running, Done} !== {exp, 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL wrap_inc[%0d]: got addr=%h run=%b done=%b, want addr=%h run=1 done=0",
                 i, InstAddress, Running, Done, exp);
      end
      if (i < 4) step();
      exp = exp + 12'h001;
    end
    BranchEn = 1'b1; BranchAbs = 1'b0; BranchOffset = 8'hFB;
    step();
    vectors++;
    if (InstAddress !== 12'hFFD) begin
      miscompares++;
      $display("FAIL wrap_rel_down: got addr=%h, want ffd", InstAddress);
    end
    BranchOffset = 8'h05;
    step();
    BranchEn = 1'b0;
    vectors++;
    if (InstAddress !== 12'h002) begin
      miscompares++;
      $display("FAIL wrap_rel_up: got addr=%h, want 002", InstAddress);
    end
  endtask

  task automatic test_stall_priority();
    BranchEn = 1'b1; BranchAbs = 1'b1; BranchTarget = 12'h030;
    step();
    Stall = 1'b1; BranchTarget = 12'h200;
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if ({InstAddress, Running} !== {12'h030, 1'b1}) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got addr=%h run=%b, want addr=030 run=1",
                 i, InstAddress, Running);
      end
    end
    Stall = 1'b0;
    step();
    vectors++;
    if (InstAddress !== 12'h200) begin
      miscompares++;
      $display("FAIL stall_release_branch: got addr=%h, want 200", InstAddress);
    end
    BranchTarget = 12'h030;
    step();
    Halt = 1'b1; Stall = 1'b1; BranchTarget = 12'h777;
    step();
    Halt = 1'b0; Stall = 1'b0; BranchEn = 1'b0;
    vectors++;
    if ({InstAddress, Running, Done} !== {12'h030, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL halt_priority: got addr=%h run=%b done=%b, want addr=030 run=0 done=1",
               InstAddress, Running, Done);
    end
  endtask

  task automatic test_back_to_back();
    Start = 1'b1; StartAddr = 12'h100;
    step();
    Start = 1'b0;
    vectors++;
    if ({InstAddress, Running, Done} !== {12'h100, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL restart_from_done: got addr=%h run=%b done=%b, want addr=100 run=1 done=0",
               InstAddress, Running, Done);
    end
    for (int i = 0; i < 5; i++) step();
    vectors++;
    if (InstAddress !== 12'h105) begin
      miscompares++;
      $display("FAIL run_to_105: got addr=%h, want 105", InstAddress);
    end
    Reset = 1'b1; Halt = 1'b1; BranchEn = 1'b1; BranchAbs = 1'b1; BranchTarget = 12'h3CC;
    step();
    idle_inputs();
    vectors++;
    if ({InstAddress, Running, Done} !== {12'h000, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_mid_run: got addr=%h run=%b done=%b, want addr=000 run=0 done=0",
               InstAddress, Running, Done);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_free_run();
    test_branch();
    test_halt_restart_wrap();
    test_stall_priority();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
